pl_tx_message_sender: RTL and testbench

Protocol-layer transmit sender that sits directly upstream of the PHY transmit interface. It buffers one USB-PD message (header plus data bytes) written by the protocol engine, then drives the PHY packet/payload handshake byte by byte. It replays the whole message on a PHY transmit failure, up to a retry limit, and returns a single completion pulse with a result code.

---
 rtl/pl_tx_message_sender_if.sv | 36 +++
 rtl/pl_tx_message_sender.sv | 164 ++++++++++++++++
 tb/tb_pl_tx_message_sender.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pl_tx_message_sender_if.sv
// Handshake bundle between the protocol engine / PHY and the TX message sender.
// slave: the sender itself. master: the environment (engine writes, PHY replies).
interface pl_tx_message_sender_if;
    logic       msg_wr_en;
    logic [7:0] msg_wr_data;
    logic       msg_send;
    logic [2:0] msg_type;
    logic       msg_busy;
    logic       msg_done;
    logic [1:0] msg_result;

    logic       pl2phy_tx_packet_en;
    logic [2:0] pl2phy_tx_packet_type;
    logic       phy2pl_tx_packet_done;
    logic       phy2pl_tx_packet_result;
    logic       pl2phy_tx_payload_en;
    logic [7:0] pl2phy_tx_payload;
    logic       pl2phy_tx_payload_last;
    logic       phy2pl_tx_payload_done;

    modport slave (
        input  msg_wr_en, msg_wr_data, msg_send, msg_type,
        input  phy2pl_tx_packet_done, phy2pl_tx_packet_result, phy2pl_tx_payload_done,
        output msg_busy, msg_done, msg_result,
        output pl2phy_tx_packet_en, pl2phy_tx_packet_type,
        output pl2phy_tx_payload_en, pl2phy_tx_payload, pl2phy_tx_payload_last
    );

    modport master (
        output msg_wr_en, msg_wr_data, msg_send, msg_type,
        output phy2pl_tx_packet_done, phy2pl_tx_packet_result, phy2pl_tx_payload_done,
        input  msg_busy, msg_done, msg_result,
        input  pl2phy_tx_packet_en, pl2phy_tx_packet_type,
        input  pl2phy_tx_payload_en, pl2phy_tx_payload, pl2phy_tx_payload_last
    );
endinterface

// File: rtl/pl_tx_message_sender.sv
// Protocol-layer TX sender: buffers one PD message, plays it byte by byte into
// the PHY, replays the whole message on PHY failure and reports one result.
// Completion is a registered pulse issued as the FSM drops back to IDLE, so
// msg_busy is already low in the msg_done cycle.
module pl_tx_message_sender #(
    parameter int MAX_BYTES   = 32,
    parameter int RETRY_MAX   = 2,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                   clk,
    input  logic                   rst,
    pl_tx_message_sender_if.slave  bus
);
    localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int WW = $clog2(MAX_BYTES + 1);
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WW-1:0] WMAX = WW'(MAX_BYTES);
    localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] RES_OK    = 2'b00;
    localparam logic [1:0] RES_DISC  = 2'b01;
    localparam logic [1:0] RES_EMPTY = 2'b10;
    localparam logic [1:0] RES_TMO   = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_WAIT_BYTE, S_WAIT_DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [MAX_BYTES];
    logic [WW-1:0]   wcnt_q;
    logic            ovf_q;
    logic [AW-1:0]   rptr_q;
    logic [RW-1:0]   retry_q;
    logic [TW-1:0]   tcnt_q;
    logic [2:0]      type_q;
    logic            done_q;
    logic [1:0]      res_q;

    logic            fin, accept, replay, adv;
    logic [1:0]      fin_code;
    logic            wr_take, wr_store, reject, last_byte;

    // Writes are only taken while idle; a write in the send cycle counts.
    assign wr_take   = (state_q == S_IDLE) && bus.msg_wr_en;
    assign wr_store  = wr_take && (wcnt_q != WMAX);
    assign reject    = ovf_q || (wr_take && (wcnt_q == WMAX)) || ((wcnt_q == '0) && !wr_take);
    assign last_byte = ((WW'(rptr_q) + WW'(1)) == wcnt_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state; packet_done outranks payload_done, which outranks the timeout.
    always_comb begin
        state_d  = state_q;
        fin      = 1'b0;
        fin_code = RES_OK;
        accept   = 1'b0;
        replay   = 1'b0;
        adv      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.msg_send) begin
                    if (reject) begin
                        fin      = 1'b1;
                        fin_code = RES_EMPTY;
                    end else begin
                        accept  = 1'b1;
                        state_d = S_START;
                    end
                end
            end
            S_START: state_d = S_BYTE;
            S_BYTE, S_WAIT_BYTE, S_WAIT_DONE: begin
                if (bus.phy2pl_tx_packet_done) begin
                    if (bus.phy2pl_tx_packet_result) begin
                        fin = 1'b1;
                    end else if (retry_q < RMAX) begin
                        replay  = 1'b1;
                        state_d = S_START;
                    end else begin
                        fin      = 1'b1;
                        fin_code = RES_DISC;
                    end
                end else if (state_q == S_BYTE) begin
                    state_d = S_WAIT_BYTE;
                end else if ((state_q == S_WAIT_BYTE) && bus.phy2pl_tx_payload_done) begin
                    adv     = !last_byte;
                    state_d = last_byte ? S_WAIT_DONE : S_BYTE;
                end else if (tcnt_q == TLIM) begin
                    fin      = 1'b1;
                    fin_code = RES_TMO;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fin) state_d = S_IDLE;
    end

    // Buffer count, pointers, retry/timeout counters and the completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
            rptr_q  <= '0;
            retry_q <= '0;
            tcnt_q  <= '0;
            type_q  <= 3'd0;
            done_q  <= 1'b0;
            res_q   <= RES_OK;
        end else begin
            done_q <= fin;
            res_q  <= fin ? fin_code : RES_OK;

            if (fin) begin
                wcnt_q <= '0;
                ovf_q  <= 1'b0;
            end else if (wr_take) begin
                if (wcnt_q == WMAX) ovf_q  <= 1'b1;
                else                wcnt_q <= wcnt_q + WW'(1);
            end

            if (accept) begin
                type_q  <= bus.msg_type;
                rptr_q  <= '0;
                retry_q <= '0;
            end else if (replay) begin
                rptr_q  <= '0;
                retry_q <= retry_q + RW'(1);
            end else if (adv) begin
                rptr_q  <= rptr_q + AW'(1);
            end

            if ((state_q == S_START) || bus.phy2pl_tx_payload_done)
                tcnt_q <= '0;
            else if ((state_q == S_WAIT_BYTE) || (state_q == S_WAIT_DONE))
                tcnt_q <= tcnt_q + TW'(1);
        end
    end

    // Message byte storage; contents need no reset since wcnt gates them.
    always_ff @(posedge clk) begin
        if (wr_store && !fin) mem[wcnt_q[AW-1:0]] <= bus.msg_wr_data;
    end

    // Outputs decoded from state; payload/last are forced low outside byte states.
    always_comb begin
        bus.msg_busy               = (state_q != S_IDLE);
        bus.msg_done               = done_q;
        bus.msg_result             = res_q;
        bus.pl2phy_tx_packet_en    = (state_q == S_START);
        bus.pl2phy_tx_packet_type  = type_q;
        bus.pl2phy_tx_payload_en   = (state_q == S_BYTE);
        bus.pl2phy_tx_payload      = 8'h00;
        bus.pl2phy_tx_payload_last = 1'b0;
        if ((state_q == S_BYTE) || (state_q == S_WAIT_BYTE)) begin
            bus.pl2phy_tx_payload      = mem[rptr_q];
            bus.pl2phy_tx_payload_last = last_byte;
        end
    end
endmodule

// File: tb/tb_pl_tx_message_sender.sv
// Bench for pl_tx_message_sender: a PHY responder, a strobe monitor fed by a
// scoreboard of expected bytes/results, and one task per scenario.
module tb_pl_tx_message_sender;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pl_tx_message_sender_if bus();

    pl_tx_message_sender #(.MAX_BYTES(32), .RETRY_MAX(2), .TIMEOUT_CYC(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] b; logic l; } exp_t;

    exp_t       exp_q[$];
    logic [1:0] res_exp[$];
    logic [7:0] wbuf[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_pay    = 0;
    int n_pkt    = 0;
    int n_done   = 0;
    int done_cyc = -1;
    int pd_cyc   = -1;
    int fail_cyc = -1;
    bit fail_pend = 1'b0;
    logic [2:0] exp_type = 3'd0;

    // PHY responder configuration
    int cfg_ack       = 3;
    int cfg_done_dly  = 2;
    int cfg_fail_left = 0;
    bit cfg_early     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [17:0] outs();
        return {bus.msg_busy, bus.msg_done, bus.msg_result, bus.pl2phy_tx_packet_en,
                bus.pl2phy_tx_packet_type, bus.pl2phy_tx_payload_en, bus.pl2phy_tx_payload,
                bus.pl2phy_tx_payload_last};
    endfunction

    // PHY model: acks each byte cfg_ack cycles after its strobe, reports packet
    // done cfg_done_dly cycles after the last ack (or right after packet_en in
    // early-fail mode), failing the first cfg_fail_left attempts.
    initial begin : phy
        int ack_t;
        int done_t;
        bit lst;
        ack_t = -1; done_t = -1; lst = 1'b0;
        bus.phy2pl_tx_packet_done   = 1'b0;
        bus.phy2pl_tx_packet_result = 1'b0;
        bus.phy2pl_tx_payload_done  = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.phy2pl_tx_packet_done   = 1'b0;
            bus.phy2pl_tx_packet_result = 1'b0;
            bus.phy2pl_tx_payload_done  = 1'b0;
            if (rst) begin
                ack_t = -1; done_t = -1;
            end else begin
                if (done_t > 0) begin
                    done_t--;
                    if (done_t == 0) begin
                        done_t = -1;
                        bus.phy2pl_tx_packet_done = 1'b1;
                        pd_cyc = cyc;
                        if (cfg_fail_left > 0) begin
                            cfg_fail_left--;
                            fail_cyc  = cyc;
                            fail_pend = 1'b1;
                        end else begin
                            bus.phy2pl_tx_packet_result = 1'b1;
                        end
                    end
                end
                if (ack_t > 0) begin
                    ack_t--;
                    if (ack_t == 0) begin
                        ack_t = -1;
                        bus.phy2pl_tx_payload_done = 1'b1;
                        if (lst) done_t = cfg_done_dly;
                    end
                end
                if (bus.pl2phy_tx_packet_en) begin
                    ack_t = -1;
                    if (cfg_early && cfg_fail_left > 0) done_t = 1;
                end
                if (bus.pl2phy_tx_payload_en && cfg_ack > 0) begin
                    ack_t = cfg_ack;
                    lst   = bus.pl2phy_tx_payload_last;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every DUT strobe / completion.
    initial begin : mon
        exp_t e;
        logic [1:0] r;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (bus.pl2phy_tx_packet_en) begin
                n_pkt++;
                n_checks++;
                if (bus.pl2phy_tx_payload_en !== 1'b0)
                    $display("FAIL strobe_overlap: payload_en=%b with packet_en, required 0", bus.pl2phy_tx_payload_en);
                else n_pass++;
                n_checks++;
                if (bus.pl2phy_tx_packet_type !== exp_type)
                    $display("FAIL packet_type: got %0d, required %0d", bus.pl2phy_tx_packet_type, exp_type);
                else n_pass++;
                if (fail_pend) begin
                    fail_pend = 1'b0;
                    n_checks++;
                    if (cyc !== fail_cyc + 1)
                        $display("FAIL retry_restart: packet_en at cycle %0d, required %0d", cyc, fail_cyc + 1);
                    else n_pass++;
                end
            end
            if (bus.pl2phy_tx_payload_en) begin
                n_pay++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL payload_unexpected: got byte %h, required no strobe", bus.pl2phy_tx_payload);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.pl2phy_tx_payload, bus.pl2phy_tx_payload_last} !== {e.b, e.l})
                        $display("FAIL payload_byte: got %h last=%b, required %h last=%b",
                                 bus.pl2phy_tx_payload, bus.pl2phy_tx_payload_last, e.b, e.l);
                    else n_pass++;
                end
            end
            if (bus.msg_done) begin
                n_done++;
                done_cyc  = cyc;
                fail_pend = 1'b0;
                n_checks++;
                if (res_exp.size() == 0) begin
                    $display("FAIL done_unexpected: got msg_done result %b, required none", bus.msg_result);
                end else begin
                    r = res_exp.pop_front();
                    if (bus.msg_result !== r)
                        $display("FAIL done_result: got %b, required %b", bus.msg_result, r);
                    else n_pass++;
                end
                n_checks++;
                if ({bus.msg_busy, bus.pl2phy_tx_packet_en, bus.pl2phy_tx_payload_en,
                     bus.pl2phy_tx_payload, bus.pl2phy_tx_payload_last} !== 12'h000)
                    $display("FAIL done_idle: busy=%b pkt_en=%b pay_en=%b pay=%h last=%b, required all 0",
                             bus.msg_busy, bus.pl2phy_tx_packet_en, bus.pl2phy_tx_payload_en,
                             bus.pl2phy_tx_payload, bus.pl2phy_tx_payload_last);
                else n_pass++;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic write_buf();
        foreach (wbuf[i]) begin
            bus.msg_wr_en   = 1'b1;
            bus.msg_wr_data = wbuf[i];
            tick();
        end
        bus.msg_wr_en = 1'b0;
    endtask

    task automatic push_attempt();
        exp_t e;
        foreach (wbuf[i]) begin
            e.b = wbuf[i];
            e.l = (i == wbuf.size() - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(output int n);
        bus.msg_send = 1'b1;
        bus.msg_type = exp_type;
        n = cyc;
        tick();
        bus.msg_send = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int start;
        start = n_done;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_done != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (outs() !== 18'h0) $display("FAIL reset_outputs: got %h, required 0", outs());
        else n_pass++;
        rst = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (outs() !== 18'h0) $display("FAIL idle_outputs: got %h, required 0", outs());
        else n_pass++;
    endtask

    task automatic test_basic();
        int n, p0, k0;
        bit ok;
        cfg_ack = 3; cfg_fail_left = 0; cfg_early = 1'b0; exp_type = 3'd0;
        wbuf.delete(); wbuf.push_back(8'h41); wbuf.push_back(8'h10);
        write_buf();
        push_attempt();
        res_exp.push_back(2'b00);
        p0 = n_pay; k0 = n_pkt;
        send(n);
        n_checks++;
        if ({bus.msg_busy, bus.pl2phy_tx_packet_en, bus.pl2phy_tx_payload_en} !== 3'b110)
            $display("FAIL basic_start: busy/pkt_en/pay_en=%b, required 110",
                     {bus.msg_busy, bus.pl2phy_tx_packet_en, bus.pl2phy_tx_payload_en});
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.pl2phy_tx_payload_en, bus.pl2phy_tx_payload} !== {1'b1, 8'h41})
            $display("FAIL basic_first_byte: en=%b byte=%h, required en=1 byte=41",
                     bus.pl2phy_tx_payload_en, bus.pl2phy_tx_payload);
        else n_pass++;
        wait_done(100, ok);
        n_checks++;
        if (!ok) $display("FAIL basic_done_timeout: no msg_done, required one within 100 cycles");
        else n_pass++;
        n_checks++;
        if (done_cyc !== pd_cyc + 1) $display("FAIL basic_done_latency: done at %0d, required %0d", done_cyc, pd_cyc + 1);
        else n_pass++;
        n_checks++;
        if (n_pay - p0 !== 2 || n_pkt - k0 !== 1)
            $display("FAIL basic_strobe_count: payload=%0d packet=%0d, required 2 and 1", n_pay - p0, n_pkt - k0);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0 || res_exp.size() != 0)
            $display("FAIL basic_scoreboard: %0d bytes %0d results left, required 0", exp_q.size(), res_exp.size());
        else n_pass++;
    endtask

    task automatic test_retry();
        int n, p0, k0;
        bit ok;
        cfg_ack = 3; cfg_fail_left = 2; cfg_early = 1'b0; exp_type = 3'd5;
        wbuf.delete(); wbuf.push_back(8'h41); wbuf.push_back(8'h10);
        write_buf();
        repeat (3) push_attempt();
        res_exp.push_back(2'b00);
        p0 = n_pay; k0 = n_pkt;
        send(n);
        wait_done(300, ok);
        n_checks++;
        if (!ok) $display("FAIL retry_done_timeout: no msg_done, required one within 300 cycles");
        else n_pass++;
        n_checks++;
        if (n_pkt - k0 !== 3 || n_pay - p0 !== 6)
            $display("FAIL retry_strobe_count: packet=%0d payload=%0d, required 3 and 6", n_pkt - k0, n_pay - p0);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0 || res_exp.size() != 0)
            $display("FAIL retry_scoreboard: %0d bytes %0d results left, required 0", exp_q.size(), res_exp.size());
        else n_pass++;
    endtask

    task automatic test_discard();
        int n, p0, k0;
        bit ok;
        exp_t e;
        cfg_ack = -1; cfg_fail_left = 3; cfg_early = 1'b1; exp_type = 3'd2;
        wbuf.delete(); wbuf.push_back(8'h41); wbuf.push_back(8'h10);
        write_buf();
        e.b = 8'h41; e.l = 1'b0;
        repeat (3) exp_q.push_back(e);
        res_exp.push_back(2'b01);
        p0 = n_pay; k0 = n_pkt;
        send(n);
        wait_done(200, ok);
        n_checks++;
        if (!ok) $display("FAIL discard_done_timeout: no msg_done, required one within 200 cycles");
        else n_pass++;
        n_checks++;
        if (done_cyc !== pd_cyc + 1) $display("FAIL discard_done_latency: done at %0d, required %0d", done_cyc, pd_cyc + 1);
        else n_pass++;
        n_checks++;
        if (n_pkt - k0 !== 3 || n_pay - p0 !== 3)
            $display("FAIL discard_strobe_count: packet=%0d payload=%0d, required 3 and 3", n_pkt - k0, n_pay - p0);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0 || res_exp.size() != 0)
            $display("FAIL discard_scoreboard: %0d bytes %0d results left, required 0", exp_q.size(), res_exp.size());
        else n_pass++;
        cfg_ack = 3; cfg_fail_left = 0; cfg_early = 1'b0;
    endtask

    task automatic test_empty_overflow();
        int n, p0, k0;
        bit ok;
        exp_type = 3'd0;
        p0 = n_pay; k0 = n_pkt;
        res_exp.push_back(2'b10);
        send(n);
        n_checks++;
        if ({bus.msg_done, bus.msg_result} !== 3'b110)
            $display("FAIL empty_done: done=%b result=%b, required done=1 result=10", bus.msg_done, bus.msg_result);
        else n_pass++;
        tick();
        wbuf.delete();
        for (int i = 0; i < 33; i++) wbuf.push_back(8'(i + 1));
        write_buf();
        res_exp.push_back(2'b10);
        send(n);
        n_checks++;
        if ({bus.msg_done, bus.msg_result} !== 3'b110)
            $display("FAIL overflow_done: done=%b result=%b, required done=1 result=10", bus.msg_done, bus.msg_result);
        else n_pass++;
        tick();
        n_checks++;
        if (n_pay != p0 || n_pkt != k0)
            $display("FAIL empty_no_strobes: payload=%0d packet=%0d, required 0 and 0", n_pay - p0, n_pkt - k0);
        else n_pass++;
        wbuf.delete(); wbuf.push_back(8'h5A);
        write_buf();
        push_attempt();
        res_exp.push_back(2'b00);
        send(n);
        wait_done(100, ok);
        n_checks++;
        if (!ok) $display("FAIL after_ovf_timeout: no msg_done, required one within 100 cycles");
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0 || res_exp.size() != 0)
            $display("FAIL after_ovf_scoreboard: %0d bytes %0d results left, required 0", exp_q.size(), res_exp.size());
        else n_pass++;
    endtask

    task automatic test_timeout();
        int n, p0;
        bit ok;
        exp_t e;
        cfg_ack = -1; exp_type = 3'd1;
        wbuf.delete(); wbuf.push_back(8'h77); wbuf.push_back(8'h88);
        write_buf();
        e.b = 8'h77; e.l = 1'b0;
        exp_q.push_back(e);
        res_exp.push_back(2'b11);
        p0 = n_pay;
        send(n);
        wait_done(60, ok);
        n_checks++;
        if (!ok) $display("FAIL timeout_no_done: no msg_done, required one within 60 cycles");
        else n_pass++;
        n_checks++;
        if (done_cyc !== n + 19) $display("FAIL timeout_latency: done at %0d, required %0d", done_cyc, n + 19);
        else n_pass++;
        n_checks++;
        if (n_pay - p0 !== 1) $display("FAIL timeout_strobes: payload=%0d, required 1", n_pay - p0);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0 || res_exp.size() != 0)
            $display("FAIL timeout_scoreboard: %0d bytes %0d results left, required 0", exp_q.size(), res_exp.size());
        else n_pass++;
        cfg_ack = 3;
    endtask

    task automatic test_wr_with_send();
        int n;
        bit ok;
        exp_t e;
        cfg_ack = 3; exp_type = 3'd3;
        wbuf.delete(); wbuf.push_back(8'h11);
        write_buf();
        e.b = 8'h11; e.l = 1'b0; exp_q.push_back(e);
        e.b = 8'h22; e.l = 1'b1; exp_q.push_back(e);
        res_exp.push_back(2'b00);
        bus.msg_wr_en   = 1'b1;
        bus.msg_wr_data = 8'h22;
        send(n);
        bus.msg_wr_en = 1'b0;
        wait_done(100, ok);
        n_checks++;
        if (!ok) $display("FAIL wr_send_timeout: no msg_done, required one within 100 cycles");
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0 || res_exp.size() != 0)
            $display("FAIL wr_send_scoreboard: %0d bytes %0d results left, required 0", exp_q.size(), res_exp.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n, p0, k0;
        bit ok;
        exp_t e;
        cfg_ack = 3; exp_type = 3'd0;
        wbuf.delete();
        for (int i = 0; i < 8; i++) wbuf.push_back(8'(8'hA0 + i));
        write_buf();
        for (int i = 0; i < 6; i++) begin
            e.b = wbuf[i]; e.l = 1'b0;
            exp_q.push_back(e);
        end
        p0 = n_pay; k0 = n_done;
        send(n);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (n_pay - p0 >= 6) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!ok) $display("FAIL rstmid_reach_byte5: payload=%0d, required 6 strobes", n_pay - p0);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if (outs() !== 18'h0) $display("FAIL rstmid_outputs: got %h, required 0", outs());
        else n_pass++;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (n_done != k0 || exp_q.size() != 0)
            $display("FAIL rstmid_no_done: done=%0d bytes_left=%0d, required 0 and 0", n_done - k0, exp_q.size());
        else n_pass++;
        wbuf.delete(); wbuf.push_back(8'hC3);
        write_buf();
        push_attempt();
        res_exp.push_back(2'b00);
        send(n);
        wait_done(100, ok);
        n_checks++;
        if (!ok) $display("FAIL rstmid_new_msg_timeout: no msg_done, required one within 100 cycles");
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0 || res_exp.size() != 0)
            $display("FAIL rstmid_scoreboard: %0d bytes %0d results left, required 0", exp_q.size(), res_exp.size());
        else n_pass++;
    endtask

    initial begin
        bus.msg_wr_en   = 1'b0;
        bus.msg_wr_data = 8'h00;
        bus.msg_send    = 1'b0;
        bus.msg_type    = 3'd0;
        test_reset();
        test_basic();
        test_retry();
        test_discard();
        test_empty_overflow();
        test_timeout();
        test_wr_with_send();
        test_reset_mid();
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
